// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Port identifiers, lock FSM state encoding and the default lock limit.
// The optional ownership-lock feature is enabled with `DMEM_ARB_LOCK_EN.
package dmem_arbiter_pkg;

    // Port identifiers, also used as the value of the round-robin pointer
    localparam logic DMEM_ARB_PORT_CORE = 1'b0;
    localparam logic DMEM_ARB_PORT_DBG  = 1'b1;

    // Default maximum number of consecutive locked grants
    localparam int DMEM_ARB_MAX_LOCK = 16;

    // Lock FSM encoding; LOCK_IDLE is the plain round-robin (unlocked) state
    typedef enum logic [1:0] {
        LOCK_IDLE = 2'd0,
        LOCK_CORE = 2'd1,
        LOCK_DBG  = 2'd2
    } lock_state_t;

    // Port that owns the memory in a given lock state (core when idle)
    function automatic logic lock_owner(input lock_state_t state);
        return (state == LOCK_DBG) ? DMEM_ARB_PORT_DBG : DMEM_ARB_PORT_CORE;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Purely combinational 2-way round-robin picker.
// Bit 0 is the core port, bit 1 the debug port. With a single requester that
// requester wins; with both, the port that was not granted last time wins.
module dmem_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pick
            // Win when alone, or when contending and not the most recent winner
            assign gnt[gi] = req[gi] & (~req[1 - gi] | (last != (gi == 1)));
        end
    endgenerate

    assign winner = gnt[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-ported data memory between the core
// load/store unit and a debug/loader master. One access per cycle, round-robin
// under contention, 1-cycle read return routed back to the issuing port.
// Optional ownership lock (core_lock/dbg_lock + lock FSM) is compiled in when
// the macro DMEM_ARB_LOCK_EN is defined; otherwise the arbiter is pure
// round-robin.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
`ifdef DMEM_ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = DMEM_ARB_MAX_LOCK
`endif
) (
    input  logic                clk,
    input  logic                rst,
`ifdef DMEM_ARB_LOCK_EN
    input  logic                core_lock,
    input  logic                dbg_lock,
`endif
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_wstrb,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    input  logic [DATA_W/8-1:0] dbg_wstrb,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_W-1:0]   dbg_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    // Round-robin pointer and read-return owner tag
    logic              last_gnt_reg;
    logic              rd_pend_reg;
    logic              rd_port_reg;

    // Last delivered read data per port, shown while that port has no rvalid
    logic [DATA_W-1:0] core_rdata_reg;
    logic [DATA_W-1:0] dbg_rdata_reg;

    // Arbitration
    logic [1:0]        req_vec;
    logic [1:0]        pick_gnt;
    logic              winner;
    logic              any_gnt;

    // Selected request fields of the winning port
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    lock_state_t       lock_state_reg;
    logic [CNT_W-1:0]  lock_cnt_reg;
    logic [CNT_W-1:0]  lock_cnt_next;
    logic              owner_req;
    logic              owner_lock;
    logic              sel_lock;

    // Lock bookkeeping: who owns the lock, and what the winner asks for
    always_comb begin
        owner_req     = core_req;
        owner_lock    = core_lock;
        if (lock_owner(lock_state_reg) == DMEM_ARB_PORT_DBG) begin
            owner_req  = dbg_req;
            owner_lock = dbg_lock;
        end
        sel_lock      = (winner == DMEM_ARB_PORT_DBG) ? dbg_lock : core_lock;
        lock_cnt_next = lock_cnt_reg + 1'b1;
    end
`endif

    // Effective requests: nothing is granted in reset, and a held lock hides
    // the other port from the picker
    always_comb begin
        req_vec = {dbg_req, core_req} & {2{~rst}};
`ifdef DMEM_ARB_LOCK_EN
        case (lock_state_reg)
            LOCK_CORE: req_vec[1] = 1'b0;
            LOCK_DBG:  req_vec[0] = 1'b0;
            default:   ;
        endcase
`endif
    end

    dmem_rr_pick u_pick (
        .req    (req_vec),
        .last   (last_gnt_reg),
        .gnt    (pick_gnt),
        .winner (winner)
    );

    assign core_gnt = pick_gnt[0];
    assign dbg_gnt  = pick_gnt[1];
    assign any_gnt  = |pick_gnt;

    // Request mux: pick the fields of the winning port
    always_comb begin
        sel_we    = core_we;
        sel_addr  = core_addr;
        sel_wdata = core_wdata;
        sel_wstrb = core_wstrb;
        if (winner == DMEM_ARB_PORT_DBG) begin
            sel_we    = dbg_we;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
            sel_wstrb = dbg_wstrb;
        end
    end

    // Memory side: quiet when idle, byte strobes only meaningful on writes
    assign mem_en    = any_gnt;
    assign mem_we    = any_gnt & sel_we;
    assign mem_addr  = any_gnt ? sel_addr : '0;
    assign mem_wdata = any_gnt ? sel_wdata : '0;
    assign mem_wstrb = (any_gnt & sel_we) ? sel_wstrb : '0;

    // Pointer and read-return tag; the pointer only moves on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg <= DMEM_ARB_PORT_DBG;
            rd_pend_reg  <= 1'b0;
            rd_port_reg  <= DMEM_ARB_PORT_CORE;
        end else begin
            rd_pend_reg <= any_gnt & ~sel_we;
            if (any_gnt) begin
                last_gnt_reg <= winner;
                rd_port_reg  <= winner;
            end
        end
    end

    // Read return goes to the tagged owner; a reset in the return cycle
    // swallows the pending data
    assign core_rvalid = rd_pend_reg & ~rst & (rd_port_reg == DMEM_ARB_PORT_CORE);
    assign dbg_rvalid  = rd_pend_reg & ~rst & (rd_port_reg == DMEM_ARB_PORT_DBG);

    assign core_rdata = core_rvalid ? mem_rdata : core_rdata_reg;
    assign dbg_rdata  = dbg_rvalid  ? mem_rdata : dbg_rdata_reg;

    // Remember the last delivered word per port so non-owners hold steady
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rdata_reg <= '0;
            dbg_rdata_reg  <= '0;
        end else begin
            if (core_rvalid) begin
                core_rdata_reg <= mem_rdata;
            end
            if (dbg_rvalid) begin
                dbg_rdata_reg <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Lock FSM: a locked grant pins ownership until the owner releases the
    // lock, drops its request, or uses up MAX_LOCK consecutive grants
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state_reg <= LOCK_IDLE;
            lock_cnt_reg   <= '0;
        end else begin
            case (lock_state_reg)
                LOCK_IDLE: begin
                    if (any_gnt && sel_lock && (MAX_LOCK > 1)) begin
                        lock_state_reg <= (winner == DMEM_ARB_PORT_DBG) ? LOCK_DBG : LOCK_CORE;
                        lock_cnt_reg   <= CNT_W'(1);
                    end
                end
                LOCK_CORE, LOCK_DBG: begin
                    if (!owner_req) begin
                        lock_state_reg <= LOCK_IDLE;
                        lock_cnt_reg   <= '0;
                    end else if (!owner_lock || (int'(lock_cnt_next) >= MAX_LOCK)) begin
                        // Owner was granted this cycle, so last_gnt already
                        // points at it and the other port wins next
                        lock_state_reg <= LOCK_IDLE;
                        lock_cnt_reg   <= '0;
                    end else begin
                        lock_cnt_reg <= lock_cnt_next;
                    end
                end
                default: begin
                    lock_state_reg <= LOCK_IDLE;
                    lock_cnt_reg   <= '0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small byte-strobed
// memory model behind it. Inputs change on the falling edge; outputs are
// sampled 1 time unit later, well away from the rising edge.
// The lock scenario is compiled when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  core_wstrb, dbg_wstrb;
    logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;
`ifdef DMEM_ARB_LOCK_EN
    logic        core_lock, dbg_lock;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mem_model [0:63];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32)
`ifdef DMEM_ARB_LOCK_EN
        ,
        .MAX_LOCK (4)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef DMEM_ARB_LOCK_EN
        .core_lock   (core_lock),
        .dbg_lock    (dbg_lock),
`endif
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_wstrb  (core_wstrb),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_wstrb   (dbg_wstrb),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata)
    );

    // Single-ported memory: byte-strobed writes, 1-cycle registered reads
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) mem_model[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem_model[mem_addr[7:2]];
            end
        end
    end

    task automatic idle_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0; core_wstrb = 4'h0;
        dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = 32'h0; dbg_wdata  = 32'h0; dbg_wstrb  = 4'h0;
`ifdef DMEM_ARB_LOCK_EN
        core_lock = 1'b0; dbg_lock = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        core_req = 1'b1;
        dbg_req  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            $display("reset cycle %0d: gnt=%b%b en=%b", c, core_gnt, dbg_gnt, mem_en);
            vectors++;
            if ({core_gnt, dbg_gnt, mem_en, mem_we, core_rvalid, dbg_rvalid} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl: got %b expected 000000",
                         {core_gnt, dbg_gnt, mem_en, mem_we, core_rvalid, dbg_rvalid});
            end
            vectors++;
            if (mem_wstrb !== 4'h0) begin
                miscompares++;
                $display("FAIL reset_wstrb: got %h expected 0", mem_wstrb);
            end
            vectors++;
            if ({core_rdata, dbg_rdata} !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_rdata: got %h/%h expected 0/0", core_rdata, dbg_rdata);
            end
        end
        // First cycle after release: core wins contention, no stale rvalid
        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("reset release: gnt=%b%b", core_gnt, dbg_gnt);
        vectors++;
        if ({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_first_gnt: got %b expected 1000", {core_gnt, dbg_gnt, core_rvalid, dbg_rvalid});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if ({core_rvalid, dbg_rvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_first_rvalid: got %b expected 10", {core_rvalid, dbg_rvalid});
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        idle_inputs();
        core_req = 1'b1; core_addr = 32'h10;
        #1;
        $display("core read 0x10: gnt=%b addr=%h", core_gnt, mem_addr);
        vectors++;
        if ({core_gnt, dbg_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL single_gnt: got gnt/en/we=%b addr=%h expected 1010 addr=00000010",
                     {core_gnt, dbg_gnt, mem_en, mem_we}, mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if ({core_rvalid, dbg_rvalid} !== 2'b10 || core_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_rvalid: got rv=%b data=%h expected 10 deadbeef", {core_rvalid, dbg_rvalid}, core_rdata);
        end
        @(negedge clk); #1;
        vectors++;
        if (core_rvalid !== 1'b0 || core_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_hold: got rv=%b data=%h expected 0 deadbeef", core_rvalid, core_rdata);
        end
    endtask

    task automatic test_write_strobe();
        @(negedge clk);
        idle_inputs();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h11223344; dbg_wstrb = 4'b0010;
        #1;
        $display("dbg write 0x20: gnt=%b we=%b wstrb=%b", dbg_gnt, mem_we, mem_wstrb);
        vectors++;
        if ({core_gnt, dbg_gnt, mem_we} !== 3'b011 || mem_wstrb !== 4'b0010 || mem_wdata !== 32'h11223344) begin
            miscompares++;
            $display("FAIL wr_gnt: got gnt/we=%b wstrb=%b wdata=%h expected 011 0010 11223344",
                     {core_gnt, dbg_gnt, mem_we}, mem_wstrb, mem_wdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if ({core_rvalid, dbg_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_no_rvalid: got %b expected 00", {core_rvalid, dbg_rvalid});
        end
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20; dbg_wstrb = 4'hF;
        #1;
        $display("dbg read 0x20: gnt=%b wstrb=%b", dbg_gnt, mem_wstrb);
        vectors++;
        if (dbg_gnt !== 1'b1 || mem_wstrb !== 4'h0) begin
            miscompares++;
            $display("FAIL rd_wstrb_zero: got gnt=%b wstrb=%b expected 1 0000", dbg_gnt, mem_wstrb);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h00003300) begin
            miscompares++;
            $display("FAIL wr_readback: got rv=%b data=%h expected 1 00003300", dbg_rvalid, dbg_rdata);
        end
    endtask

    task automatic test_contention();
        logic exp_core;
        logic prev_core;
        exp_core  = 1'b1;
        prev_core = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
            dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h44;
            #1;
            $display("contention cycle %0d: gnt=%b%b", c, core_gnt, dbg_gnt);
            vectors++;
            if ({core_gnt, dbg_gnt} !== (exp_core ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL cont_gnt%0d: got %b%b expected %b", c, core_gnt, dbg_gnt, exp_core ? 2'b10 : 2'b01);
            end
            vectors++;
            if (c == 0) begin
                if ({core_rvalid, dbg_rvalid} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL cont_rv%0d: got %b expected 00", c, {core_rvalid, dbg_rvalid});
                end
            end else if (prev_core) begin
                if ({core_rvalid, dbg_rvalid} !== 2'b10 || core_rdata !== 32'hA0A0A0A0) begin
                    miscompares++;
                    $display("FAIL cont_rv%0d: got %b data=%h expected 10 a0a0a0a0", c, {core_rvalid, dbg_rvalid}, core_rdata);
                end
            end else begin
                if ({core_rvalid, dbg_rvalid} !== 2'b01 || dbg_rdata !== 32'hB0B0B0B0) begin
                    miscompares++;
                    $display("FAIL cont_rv%0d: got %b data=%h expected 01 b0b0b0b0", c, {core_rvalid, dbg_rvalid}, dbg_rdata);
                end
            end
            prev_core = exp_core;
            exp_core  = ~exp_core;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if ({core_rvalid, dbg_rvalid} !== 2'b01 || dbg_rdata !== 32'hB0B0B0B0) begin
            miscompares++;
            $display("FAIL cont_last_rv: got %b data=%h expected 01 b0b0b0b0", {core_rvalid, dbg_rvalid}, dbg_rdata);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle_inputs();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h30; core_wdata = 32'hCAFEF00D; core_wstrb = 4'hF;
        #1;
        vectors++;
        if (core_gnt !== 1'b1 || mem_we !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_wr: got gnt=%b we=%b expected 1 1", core_gnt, mem_we);
        end
        @(negedge clk);
        core_we = 1'b0; core_wstrb = 4'h0;
        #1;
        vectors++;
        if (core_gnt !== 1'b1 || mem_we !== 1'b0 || core_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_rd: got gnt=%b we=%b rv=%b expected 1 0 0", core_gnt, mem_we, core_rvalid);
        end
        // Core read return and a new dbg grant in the same cycle
        @(negedge clk);
        idle_inputs();
        dbg_req = 1'b1; dbg_addr = 32'h10;
        #1;
        $display("b2b overlap: core_rv=%b data=%h dbg_gnt=%b", core_rvalid, core_rdata, dbg_gnt);
        vectors++;
        if ({core_rvalid, dbg_gnt} !== 2'b11 || core_rdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL b2b_overlap: got rv/gnt=%b data=%h expected 11 cafef00d", {core_rvalid, dbg_gnt}, core_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if ({core_rvalid, dbg_rvalid} !== 2'b01 || dbg_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL b2b_dbg_rv: got %b data=%h expected 01 deadbeef", {core_rvalid, dbg_rvalid}, dbg_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        idle_inputs();
        core_req = 1'b1; core_addr = 32'h10;
        #1;
        vectors++;
        if (core_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_gnt: got %b expected 1", core_gnt);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        vectors++;
        if ({core_rvalid, dbg_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_during: got %b expected 00", {core_rvalid, dbg_rvalid});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({core_rvalid, dbg_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_release: got %b expected 00", {core_rvalid, dbg_rvalid});
        end
        @(negedge clk); #1;
        $display("mid-read reset: core_rv=%b rdata=%h", core_rvalid, core_rdata);
        vectors++;
        if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_after: got rv=%b data=%h expected 0 00000000", core_rvalid, core_rdata);
        end
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            core_req = 1'b1; core_lock = 1'b1; core_we = 1'b0; core_addr = 32'h10;
            dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h44;
            #1;
            $display("lock cycle %0d: gnt=%b%b", c, core_gnt, dbg_gnt);
            vectors++;
            if ({core_gnt, dbg_gnt} !== ((c < 4) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL lock_gnt%0d: got %b%b expected %b", c, core_gnt, dbg_gnt, (c < 4) ? 2'b10 : 2'b01);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
        mem_model[32'h10 >> 2] = 32'hDEADBEEF;
        mem_model[32'h40 >> 2] = 32'hA0A0A0A0;
        mem_model[32'h44 >> 2] = 32'hB0B0B0B0;
        idle_inputs();
        rst = 1'b1;

        test_reset();
        test_single_read();
        test_write_strobe();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
